// File: rtl/spi_reg_bank_arb.sv
// Register bank shared between an SPI register port and one local requester.
// SPI writes are buffered in a one-entry slot and arbitrated round-robin
// against local accesses. SPI_ARB_FIXED_PRIO_EN makes SPI win every conflict.
module spi_reg_bank_arb #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [REG_W-1:0]  spi_wdata,
  input  logic              spi_wr_dv,
  output logic [REG_W-1:0]  spi_rdata,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [REG_W-1:0]  loc_wdata,
  output logic              loc_gnt,
  output logic [REG_W-1:0]  loc_rdata,
  output logic              loc_rvalid,
  input  logic              clr_ovr,
  output logic [7:0]        status,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Local handshake: loc_req rises and stays high with loc_we/loc_addr/loc_wdata
  // stable; loc_gnt pulses for the one cycle in which the access is performed,
  // after which the requester may drop loc_req. loc_rvalid follows a read grant
  // by one cycle with loc_rdata valid alongside it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPI_WR  = 2'd1,
    LOC_ACC = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [REG_W-1:0]  bank [DEPTH];
  logic [ADDR_W-1:0] pend_addr;
  logic [REG_W-1:0]  pend_data;
  logic              spi_pend;
  logic              ovr;
  logic              last_grant;
  logic [3:0]        conflict_cnt;
  logic              rvalid_q;
  logic              conflict;
  logic              consume;
  logic              ovr_set;

  always_comb begin
    state_nxt = state;
    conflict  = 1'b0;
    case (state)
      IDLE: begin
        if (spi_pend && loc_req) begin
          conflict = 1'b1;
`ifdef SPI_ARB_FIXED_PRIO_EN
          state_nxt = SPI_WR;
`else
          // last_grant: 0 = SPI, 1 = LOC; the other requester wins.
          state_nxt = last_grant ? SPI_WR : LOC_ACC;
`endif
        end else if (spi_pend) begin
          state_nxt = SPI_WR;
        end else if (loc_req) begin
          state_nxt = LOC_ACC;
        end
      end
      SPI_WR:  state_nxt = IDLE;
      LOC_ACC: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign consume = (state == SPI_WR);
  assign ovr_set = spi_wr_dv && spi_pend && !consume;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state        <= IDLE;
      pend_addr    <= '0;
      pend_data    <= '0;
      spi_pend     <= 1'b0;
      ovr          <= 1'b0;
      last_grant   <= 1'b1;
      conflict_cnt <= 4'd0;
      loc_rdata    <= '0;
      rvalid_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (ena) begin
        state <= state_nxt;
        if (spi_wr_dv) begin
          pend_addr <= spi_addr;
          pend_data <= spi_wdata;
          spi_pend  <= 1'b1;
        end else if (consume) begin
          spi_pend <= 1'b0;
        end
        if (ovr_set) ovr <= 1'b1;
        else if (clr_ovr) ovr <= 1'b0;
        if (conflict && conflict_cnt != 4'hF) conflict_cnt <= conflict_cnt + 4'd1;
        if (state == SPI_WR) begin
          bank[pend_addr] <= pend_data;
          last_grant      <= 1'b0;
        end
        if (state == LOC_ACC) begin
          last_grant <= 1'b1;
          if (loc_we) begin
            bank[loc_addr] <= loc_wdata;
          end else begin
            loc_rdata <= bank[loc_addr];
            rvalid_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign spi_rdata  = bank[spi_addr];
  assign loc_gnt    = rstb && ena && (state == LOC_ACC);
  assign loc_rvalid = rvalid_q && ena;
  assign status     = {(state != IDLE), spi_pend, ovr, last_grant, conflict_cnt};
  assign dbg_state  = state;

endmodule

// File: tb/tb_spi_reg_bank_arb.sv
// Directed bench for spi_reg_bank_arb: inputs change and outputs are sampled
// 1 ns after each rising edge; expected values are hand-computed constants.
module tb_spi_reg_bank_arb;

  logic       clk = 1'b0;
  logic       rstb, ena;
  logic [2:0] spi_addr, loc_addr;
  logic [7:0] spi_wdata, loc_wdata;
  logic       spi_wr_dv, loc_req, loc_we, clr_ovr;
  logic [7:0] spi_rdata, loc_rdata, status;
  logic       loc_gnt, loc_rvalid;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;

  spi_reg_bank_arb #(.ADDR_W(3), .REG_W(8)) dut (
    .clk(clk), .rstb(rstb), .ena(ena),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wr_dv(spi_wr_dv),
    .spi_rdata(spi_rdata),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr),
    .loc_wdata(loc_wdata), .loc_gnt(loc_gnt), .loc_rdata(loc_rdata),
    .loc_rvalid(loc_rvalid), .clr_ovr(clr_ovr), .status(status),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] a, input logic [7:0] exp);
    spi_addr = a;
    #1;
    chk(tag, spi_rdata, exp);
  endtask

  // driver tasks
  task automatic spi_dv(input logic [2:0] a, input logic [7:0] d);
    spi_addr  = a;
    spi_wdata = d;
    spi_wr_dv = 1'b1;
  endtask

  task automatic loc_set(input logic we, input logic [2:0] a, input logic [7:0] d);
    loc_req   = 1'b1;
    loc_we    = we;
    loc_addr  = a;
    loc_wdata = d;
  endtask

  initial begin
    rstb = 1'b0; ena = 1'b1; spi_addr = '0; spi_wdata = '0; spi_wr_dv = 1'b0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0; clr_ovr = 1'b0;
    tick(); tick();
    rstb = 1'b1;

    chk("rst_status", status, 8'h10);
    chk("rst_state", 8'(dbg_state), 8'h00);
    chk("rst_gnt", 8'(loc_gnt), 8'h00);
    chk("rst_rvalid", 8'(loc_rvalid), 8'h00);
    for (int a = 0; a < 8; a++) chk_rd("rst_bank", 3'(a), 8'h00);

    // single SPI write
    spi_dv(3'd3, 8'hA5);
    tick(); spi_wr_dv = 1'b0;
    chk("spi_pend", status, 8'h50);
    tick();
    chk("spi_busy", status, 8'hD0);
    tick();
    chk_rd("spi_wr_data", 3'd3, 8'hA5);
    chk("spi_done", status, 8'h00);

    // local write then local read
    loc_set(1'b1, 3'd5, 8'h3C);
    tick();
    chk("lw_gnt", 8'(loc_gnt), 8'h01);
    tick(); loc_req = 1'b0;
    chk("lw_gnt_end", 8'(loc_gnt), 8'h00);
    chk("lw_status", status, 8'h10);
    loc_set(1'b0, 3'd5, 8'h00);
    tick();
    chk("lr_gnt", 8'(loc_gnt), 8'h01);
    tick(); loc_req = 1'b0;
    chk("lr_rvalid", 8'(loc_rvalid), 8'h01);
    chk("lr_rdata", loc_rdata, 8'h3C);
    tick();
    chk("lr_rvalid_end", 8'(loc_rvalid), 8'h00);
    chk_rd("lw_spi_view", 3'd5, 8'h3C);

    // conflict 1: last_grant = LOC, so SPI wins
    spi_dv(3'd1, 8'h11);
    tick(); spi_wr_dv = 1'b0;
    loc_set(1'b1, 3'd2, 8'h22);
    tick();
    chk("c1_status", status, 8'hD1);
    chk("c1_gnt", 8'(loc_gnt), 8'h00);
    tick();
    chk("c1_after_spi", status, 8'h01);
    tick();
    chk("c1_loc_gnt", 8'(loc_gnt), 8'h01);
    tick(); loc_req = 1'b0;
    chk("c1_end", status, 8'h11);

    // conflict 2 (SPI wins), SPI slot reloaded during SPI_WR, then conflict 3
    spi_dv(3'd1, 8'h33);
    tick(); spi_wr_dv = 1'b0;
    loc_set(1'b1, 3'd2, 8'h44);
    tick();
    chk("c2_status", status, 8'hD2);
    spi_dv(3'd6, 8'h66);
    tick(); spi_wr_dv = 1'b0;
    chk("c2_reload", status, 8'h42);
    tick();
    chk("c3_status", status, 8'hC3);
`ifdef SPI_ARB_FIXED_PRIO_EN
    chk("c3_gnt", 8'(loc_gnt), 8'h00);
    tick();
    tick();
    chk("c3_loc_gnt", 8'(loc_gnt), 8'h01);
    tick(); loc_req = 1'b0;
`else
    chk("c3_gnt", 8'(loc_gnt), 8'h01);
    tick(); loc_req = 1'b0;
    tick();
    tick();
`endif
    chk_rd("c_bank1", 3'd1, 8'h33);
    chk_rd("c_bank2", 3'd2, 8'h44);
    chk_rd("c_bank6", 3'd6, 8'h66);
    chk("c_cnt", status & 8'h0F, 8'h03);
    chk("c_idle", status & 8'hE0, 8'h00);

    // overrun: second strobe while the slot is full and not being consumed
    loc_set(1'b1, 3'd7, 8'h77);
    spi_dv(3'd4, 8'h41);
    tick();
    spi_wdata = 8'h42;
    chk("ov_gnt", 8'(loc_gnt), 8'h01);
    tick(); spi_wr_dv = 1'b0; loc_req = 1'b0;
    chk("ov_status", status, 8'h73);
    tick();
    tick();
    chk_rd("ov_data", 3'd4, 8'h42);
    chk_rd("ov_loc_data", 3'd7, 8'h77);
    chk("ov_sticky", status, 8'h23);
    clr_ovr = 1'b1;
    tick(); clr_ovr = 1'b0;
    chk("ov_clear", status, 8'h03);

    // saturate conflict_cnt
    for (int i = 0; i < 14; i++) begin
      spi_dv(3'd0, 8'(i));
      tick(); spi_wr_dv = 1'b0;
      loc_set(1'b0, 3'd0, 8'h00);
      tick();
      for (int k = 0; k < 6; k++) begin
        if (loc_gnt) break;
        tick();
      end
      chk("sat_gnt", 8'(loc_gnt), 8'h01);
      tick(); loc_req = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (status[7:6] == 2'b00) break;
        tick();
      end
      chk("sat_idle", status & 8'hC0, 8'h00);
    end
    chk("sat_cnt", status & 8'h0F, 8'h0F);

    // ena low holds a pending write and ignores strobes
    spi_dv(3'd5, 8'h99);
    tick(); spi_wr_dv = 1'b0;
    ena = 1'b0;
    spi_dv(3'd5, 8'hEE);
    tick(); tick(); tick();
    spi_wr_dv = 1'b0;
    chk("ena_hold", status & 8'hEF, 8'h4F);
    chk_rd("ena_bank", 3'd5, 8'h3C);
    ena = 1'b1;
    tick();
    tick();
    chk_rd("ena_resume", 3'd5, 8'h99);
    chk("ena_idle", status & 8'hE0, 8'h00);

    // ena low masks loc_gnt; reset during LOC_ACC aborts the write
    loc_set(1'b1, 3'd7, 8'hBB);
    tick();
    chk("la_gnt", 8'(loc_gnt), 8'h01);
    ena = 1'b0;
    #1;
    chk("la_ena_gnt", 8'(loc_gnt), 8'h00);
    ena = 1'b1;
    rstb = 1'b0;
    #1;
    chk("la_rst_gnt", 8'(loc_gnt), 8'h00);
    tick();
    loc_req = 1'b0;
    rstb = 1'b1;
    chk("la_rst_status", status, 8'h10);
    chk_rd("la_rst_bank7", 3'd7, 8'h00);
    chk_rd("la_rst_bank5", 3'd5, 8'h00);
    chk("la_rst_rvalid", 8'(loc_rvalid), 8'h00);
    chk("la_rst_rdata", loc_rdata, 8'h00);
    tick();
    chk("la_post_gnt", 8'(loc_gnt), 8'h00);
    chk_rd("la_post_bank7", 3'd7, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
